// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data responder: FSM encodings and default widths.
package dmem_responder_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmrState_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word store: synchronous write, registered read, async clear.
// Read data is zero except in the cycle after a read strobe; there is no backpressure.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rdEn) begin
      rdata <= mem[idx];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: one access at a time, WAIT_CYC wait states then a 1-cycle response.
// req_ready only in IDLE; stall_o holds the pipeline from request until the response cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall_o
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

  dmrState_t         state, nextState;
  logic [CNT_W-1:0]  waitCnt;
  logic              reqWeQ;
  logic [ADDR_W-1:0] reqAddrQ;
  logic [DATA_W-1:0] reqWdataQ;

  logic              idle, accept, curWe, curErr, enterResp, memWr, memRd;
  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curWdata;

  assign idle   = (state == DMR_IDLE);
  assign accept = idle & req_valid;

  // With zero wait states the array is hit on the accept edge itself, so use the live request.
  assign curWe    = idle ? req_we    : reqWeQ;
  assign curAddr  = idle ? req_addr  : reqAddrQ;
  assign curWdata = idle ? req_wdata : reqWdataQ;
  assign curErr   = ({1'b0, curAddr} >= DEPTH_V);

  assign enterResp = (nextState == DMR_RESP);
  assign memWr     = enterResp & curWe & ~curErr;
  assign memRd     = enterResp & ~curWe & ~curErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DMR_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = DMR_IDLE;
    unique case (state)
      DMR_IDLE: begin
        if (req_valid) nextState = (WAIT_CYC == 0) ? DMR_RESP : DMR_WAIT;
        else           nextState = DMR_IDLE;
      end
      DMR_WAIT: nextState = (waitCnt == '0) ? DMR_RESP : DMR_WAIT;
      DMR_RESP: nextState = DMR_IDLE;
      default:  nextState = DMR_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    stall_o   = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    unique case (state)
      DMR_IDLE: begin
        req_ready = 1'b1;
        stall_o   = req_valid;
      end
      DMR_WAIT: stall_o = 1'b1;
      DMR_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = curErr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt   <= '0;
      reqWeQ    <= 1'b0;
      reqAddrQ  <= '0;
      reqWdataQ <= '0;
    end else begin
      if (accept) begin
        waitCnt   <= CNT_INIT;
        reqWeQ    <= req_we;
        reqAddrQ  <= req_addr;
        reqWdataQ <= req_wdata;
      end else if (state == DMR_WAIT && waitCnt != '0) begin
        waitCnt <= waitCnt - 1'b1;
      end
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .wrEn  (memWr),
    .rdEn  (memRd),
    .idx   (curAddr[IDX_W-1:0]),
    .wdata (curWdata),
    .rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: unit 0 = WAIT_CYC 2 / DEPTH 16, unit 1 = WAIT_CYC 0 / DEPTH 32; model + directed literals.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid [2];
  logic        reqWe    [2];
  logic [4:0]  reqAddr  [2];
  logic [31:0] reqWdata [2];
  logic        reqReady [2];
  logic        rspValid [2];
  logic [31:0] rspRdata [2];
  logic        rspErr   [2];
  logic        stallO   [2];

  int checks   = 0;
  int failures = 0;
  bit modelOn  = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .WAIT_CYC(2)) dutA (
    .clk(clk), .rst_n(rstN),
    .req_valid(reqValid[0]), .req_we(reqWe[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .req_ready(reqReady[0]), .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]),
    .rsp_err(rspErr[0]), .stall_o(stallO[0])
  );

  dmem_responder #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .WAIT_CYC(0)) dutB (
    .clk(clk), .rst_n(rstN),
    .req_valid(reqValid[1]), .req_we(reqWe[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .req_ready(reqReady[1]), .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]),
    .rsp_err(rspErr[1]), .stall_o(stallO[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: an accepted access occupies the unit for WAIT_CYC+1 cycles, the last being the response.
  int          waitOf  [2] = '{2, 0};
  int          depthOf [2] = '{16, 32};
  logic [31:0] mMem    [2][32];
  int          left    [2];
  logic [31:0] mData   [2];
  logic        mErr    [2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      left[u] = 0; mData[u] = '0; mErr[u] = 1'b0;
      for (int a = 0; a < 32; a++) mMem[u][a] = '0;
    end
  end

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int u = 0; u < 2; u++) begin
        left[u] = 0;
        for (int a = 0; a < 32; a++) mMem[u][a] = '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (left[u] > 0) begin
          left[u] = left[u] - 1;
        end else if (reqValid[u]) begin
          left[u] = waitOf[u] + 1;
          mErr[u] = (int'(reqAddr[u]) >= depthOf[u]);
          mData[u] = '0;
          if (!mErr[u]) begin
            if (reqWe[u]) mMem[u][reqAddr[u]] = reqWdata[u];
            else          mData[u] = mMem[u][reqAddr[u]];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d req_ready", u), 32'(reqReady[u]), 32'(left[u] == 0));
        chk($sformatf("u%0d stall_o", u), 32'(stallO[u]), 32'((left[u] > 1) || (left[u] == 0 && reqValid[u])));
        chk($sformatf("u%0d rsp_valid", u), 32'(rspValid[u]), 32'(left[u] == 1));
        if (left[u] == 1) begin
          chk($sformatf("u%0d rsp_rdata", u), rspRdata[u], mData[u]);
          chk($sformatf("u%0d rsp_err", u), 32'(rspErr[u]), 32'(mErr[u]));
        end else begin
          chk($sformatf("u%0d rsp_err idle", u), 32'(rspErr[u]), 32'd0);
        end
      end
    end
  end

  // One access from IDLE; returns response data, error, cycles after accept, stall cycles, ready in RESP.
  task automatic doAccess(input int u, input bit we, input logic [4:0] addr, input logic [31:0] wdata,
                          input bit scramble, output logic [31:0] rdata, output logic err,
                          output int lat, output int stalls, output logic rdyRsp);
    bit got;
    @(posedge clk); #1;
    reqValid[u] = 1'b1; reqWe[u] = we; reqAddr[u] = addr; reqWdata[u] = wdata;
    stalls = 0; got = 1'b0; rdata = 'x; err = 1'bx; rdyRsp = 1'bx;
    @(negedge clk);
    if (stallO[u]) stalls++;
    @(posedge clk); #1;
    reqValid[u] = 1'b0;
    if (scramble) begin
      reqAddr[u] = ~addr; reqWdata[u] = 32'h0BAD_F00D; reqWe[u] = ~we;
    end
    lat = 1;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (rspValid[u]) begin
        got = 1'b1; rdata = rspRdata[u]; err = rspErr[u]; rdyRsp = reqReady[u];
      end else begin
        if (stallO[u]) stalls++;
        @(posedge clk);
        lat++;
      end
    end
    if (!got) chk("response timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e, r;
    int          lat, st, cnt;

    rstN = 1'b0;
    for (int u = 0; u < 2; u++) begin
      reqValid[u] = 1'b0; reqWe[u] = 1'b0; reqAddr[u] = '0; reqWdata[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset u%0d rsp_valid", u), 32'(rspValid[u]), 32'd0);
      chk($sformatf("reset u%0d rsp_rdata", u), rspRdata[u], 32'd0);
      chk($sformatf("reset u%0d rsp_err", u), 32'(rspErr[u]), 32'd0);
      chk($sformatf("reset u%0d req_ready", u), 32'(reqReady[u]), 32'd1);
      chk($sformatf("reset u%0d stall_o", u), 32'(stallO[u]), 32'd0);
    end
    @(negedge clk);
    rstN = 1'b1;
    modelOn = 1'b1;

    // Store then loads with two wait states.
    doAccess(0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, d, e, lat, st, r);
    chk("t1 stall cycles", 32'(st), 32'd3);
    chk("t1 latency", 32'(lat), 32'd3);
    chk("t1 rsp_err", 32'(e), 32'd0);
    chk("t1 store rdata", d, 32'd0);
    doAccess(0, 1'b0, 5'd3, 32'h0, 1'b0, d, e, lat, st, r);
    chk("t2 load addr3", d, 32'hDEADBEEF);
    chk("t2 latency", 32'(lat), 32'd3);
    doAccess(0, 1'b0, 5'd4, 32'h0, 1'b0, d, e, lat, st, r);
    chk("t2 load addr4", d, 32'h0);

    // Zero wait states.
    doAccess(1, 1'b1, 5'd1, 32'h12345678, 1'b0, d, e, lat, st, r);
    chk("t3 store latency", 32'(lat), 32'd1);
    chk("t3 ready in RESP", 32'(r), 32'd0);
    doAccess(1, 1'b0, 5'd1, 32'h0, 1'b0, d, e, lat, st, r);
    chk("t3 load addr1", d, 32'h12345678);
    chk("t3 load latency", 32'(lat), 32'd1);
    chk("t3 ready in RESP load", 32'(r), 32'd0);

    // Out-of-range address on a 16-word array.
    doAccess(0, 1'b1, 5'd20, 32'hFFFFFFFF, 1'b0, d, e, lat, st, r);
    chk("t4 store err", 32'(e), 32'd1);
    doAccess(0, 1'b0, 5'd20, 32'h0, 1'b0, d, e, lat, st, r);
    chk("t4 load err", 32'(e), 32'd1);
    chk("t4 load data", d, 32'h0);
    chk("t4 err latency", 32'(lat), 32'd3);
    doAccess(0, 1'b0, 5'd4, 32'h0, 1'b0, d, e, lat, st, r);
    chk("t4 addr4 unchanged", d, 32'h0);
    doAccess(0, 1'b0, 5'd3, 32'h0, 1'b0, d, e, lat, st, r);
    chk("t4 addr3 unchanged", d, 32'hDEADBEEF);

    // Request inputs change after accept.
    doAccess(0, 1'b1, 5'd7, 32'h11223344, 1'b1, d, e, lat, st, r);
    chk("t6 scrambled store err", 32'(e), 32'd0);
    doAccess(0, 1'b0, 5'd7, 32'h0, 1'b0, d, e, lat, st, r);
    chk("t6 load addr7", d, 32'h11223344);
    doAccess(0, 1'b0, 5'd3, 32'h0, 1'b1, d, e, lat, st, r);
    chk("t6 scrambled load addr3", d, 32'hDEADBEEF);
    chk("t6 scrambled load err", 32'(e), 32'd0);

    // Reset in the middle of a store's wait states.
    @(posedge clk); #1;
    reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = 5'd5; reqWdata[0] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    chk("t5 in WAIT stall", 32'(stallO[0]), 32'd1);
    #2 rstN = 1'b0;
    #1;
    chk("t5 async rsp_valid", 32'(rspValid[0]), 32'd0);
    chk("t5 async stall_o", 32'(stallO[0]), 32'd0);
    chk("t5 async rsp_rdata", rspRdata[0], 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rspValid[0]) cnt++;
    end
    chk("t5 no response after reset", 32'(cnt), 32'd0);
    doAccess(0, 1'b0, 5'd5, 32'h0, 1'b0, d, e, lat, st, r);
    chk("t5 load addr5 after reset", d, 32'h0);
    doAccess(0, 1'b0, 5'd3, 32'h0, 1'b0, d, e, lat, st, r);
    chk("t5 addr3 cleared", d, 32'h0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
